seq_controller: RTL and testbench

//  Multi-cycle FSM that sequences the 8-bit register-file/ALU datapath of the
//  6-instruction processor: fetches from program memory, decodes, drives the
//  RF/ALU/mux selects and the data-memory strobes. Sits beside operational_block

---
 rtl/seq_controller.sv | 190 +++++++++++++++++++
 tb/tb_seq_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// Multi-cycle sequencer for the 6-instruction 8-bit processor: fetches from
// program memory, decodes, and drives RF/ALU/mux selects and data-memory strobes.
module seq_controller #(
  parameter int unsigned        PC_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] i_addr,
  output logic            i_rd,
  input  logic [15:0]     i_data,
  output logic [15:0]     d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic [7:0]      rf_w_data,
  output logic [1:0]      rf_s,
  output logic [3:0]      rf_w_addr,
  output logic [3:0]      rf_rp_addr,
  output logic [3:0]      rf_rq_addr,
  output logic            rf_w_wr,
  output logic            rf_rp_rd,
  output logic            rf_rq_rd,
  input  logic            rf_rp_zero,
  output logic [1:0]      alu_s,
  output logic            instr_done,
  output logic            illegal_op
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE,
    S_ADD, S_SUB, S_LDC, S_JMPZ, S_JMP
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_LDC   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JMPZ  = 4'd5;

  localparam logic [1:0] RF_SEL_ALU  = 2'b00;
  localparam logic [1:0] RF_SEL_MEM  = 2'b01;
  localparam logic [1:0] RF_SEL_IMM  = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b01;
  localparam logic [1:0] ALU_SUB     = 2'b10;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      op, ra, rb, rc;
  logic [7:0]      imm;
  logic [PC_W-1:0] off_sext;

  assign op       = ir_q[15:12];
  assign ra       = ir_q[11:8];
  assign rb       = ir_q[7:4];
  assign rc       = ir_q[3:0];
  assign imm      = ir_q[7:0];
  assign off_sext = PC_W'($signed(imm));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= S_INIT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default here, so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    i_addr     = '0;
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_s       = '0;
    rf_w_addr  = '0;
    rf_rp_addr = '0;
    rf_rq_addr = '0;
    rf_w_wr    = 1'b0;
    rf_rp_rd   = 1'b0;
    rf_rq_rd   = 1'b0;
    alu_s      = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        i_rd    = 1'b1;
        i_addr  = pc_q;
        ir_d    = i_data;
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (op)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_LDC:   state_d = S_LDC;
          OP_SUB:   state_d = S_SUB;
          OP_JMPZ:  state_d = S_JMPZ;
          default: begin
            // Undefined opcode retires as a NOP; PC already points past it.
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_LOAD: begin
        d_addr     = {8'h00, imm};
        d_rd       = 1'b1;
        rf_s       = RF_SEL_MEM;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_STORE: begin
        d_addr     = {8'h00, imm};
        d_wr       = 1'b1;
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rq_addr = rc;
        rf_rp_rd   = 1'b1;
        rf_rq_rd   = 1'b1;
        alu_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        rf_s       = RF_SEL_ALU;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_LDC: begin
        rf_w_data  = imm;
        rf_s       = RF_SEL_IMM;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JMPZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
        if (rf_rp_zero) begin
          state_d = S_JMP;
        end else begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_JMP: begin
        // PC was already advanced past the JMPZ, hence the -1.
        pc_d       = pc_q + off_sext - PC_ONE;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a behavioural RF/ALU/memory environment
// reacts to the strobes; outputs are compared at the falling clock edge.
module tb_seq_controller;

  typedef struct packed {
    logic [15:0] i_addr;
    logic        i_rd;
    logic [15:0] d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [7:0]  rf_w_data;
    logic [1:0]  rf_s;
    logic [3:0]  rf_w_addr;
    logic [3:0]  rf_rp_addr;
    logic [3:0]  rf_rq_addr;
    logic        rf_w_wr;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic [1:0]  alu_s;
    logic        instr_done;
    logic        illegal_op;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data;
  logic [15:0] d_addr;
  logic        d_rd, d_wr;
  logic [7:0]  rf_w_data;
  logic [1:0]  rf_s;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic        rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic        rf_rp_zero;
  logic [1:0]  alu_s;
  logic        instr_done, illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  seq_controller dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .i_data     (i_data),
    .d_addr     (d_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .rf_w_data  (rf_w_data),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_rp_addr (rf_rp_addr),
    .rf_rq_addr (rf_rq_addr),
    .rf_w_wr    (rf_w_wr),
    .rf_rp_rd   (rf_rp_rd),
    .rf_rq_rd   (rf_rq_rd),
    .rf_rp_zero (rf_rp_zero),
    .alu_s      (alu_s),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Environment: program ROM, register file, ALU, data memory.
  logic [15:0] prog      [16];
  logic [7:0]  rf        [16];
  logic [7:0]  dmem      [256];
  logic [7:0]  rf_init   [16];
  logic [7:0]  dmem_init [256];
  logic        env_load;
  logic [7:0]  p_val, q_val, alu_y, w_val;
  out_t        obs;

  always_comb i_data = (i_addr < 16'd16) ? prog[i_addr[3:0]] : 16'h3000;
  always_comb p_val  = rf[rf_rp_addr];
  always_comb q_val  = rf[rf_rq_addr];
  always_comb rf_rp_zero = rf_rp_rd && (p_val == 8'h00);

  always_comb begin
    alu_y = p_val;
    case (alu_s)
      2'b01:   alu_y = p_val + q_val;
      2'b10:   alu_y = p_val - q_val;
      default: alu_y = p_val;
    endcase
    w_val = alu_y;
    case (rf_s)
      2'b01:   w_val = dmem[d_addr[7:0]];
      2'b10:   w_val = rf_w_data;
      default: w_val = alu_y;
    endcase
  end

  always @(posedge clk) begin
    if (env_load) begin
      for (int i = 0; i < 16; i++)  rf[i]   <= rf_init[i];
      for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
    end else begin
      if (rf_w_wr) rf[rf_w_addr] <= w_val;
      if (d_wr)    dmem[d_addr[7:0]] <= p_val;
    end
  end

  always_comb obs = {i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_s, rf_w_addr,
                     rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, alu_s,
                     instr_done, illegal_op};

  // Expected output vectors, built straight from the state descriptions.
  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_fetch(input logic [15:0] pc);
    out_t o = '0;
    o.i_rd = 1'b1; o.i_addr = pc;
    return o;
  endfunction

  function automatic out_t o_ldc(input logic [3:0] ra, input logic [7:0] c);
    out_t o = '0;
    o.rf_w_data = c; o.rf_s = 2'b10; o.rf_w_addr = ra; o.rf_w_wr = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_load(input logic [3:0] ra, input logic [7:0] d);
    out_t o = '0;
    o.d_rd = 1'b1; o.d_addr = {8'h00, d}; o.rf_s = 2'b01; o.rf_w_addr = ra;
    o.rf_w_wr = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_store(input logic [3:0] ra, input logic [7:0] d);
    out_t o = '0;
    o.d_wr = 1'b1; o.d_addr = {8'h00, d}; o.rf_rp_addr = ra; o.rf_rp_rd = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_alu(input logic [3:0] ra, rb, rc, input logic [1:0] op);
    out_t o = '0;
    o.rf_rp_addr = rb; o.rf_rq_addr = rc; o.rf_rp_rd = 1'b1; o.rf_rq_rd = 1'b1;
    o.alu_s = op; o.rf_s = 2'b00; o.rf_w_addr = ra; o.rf_w_wr = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_jmpz(input logic [3:0] ra, input logic done);
    out_t o = '0;
    o.rf_rp_addr = ra; o.rf_rp_rd = 1'b1; o.instr_done = done;
    return o;
  endfunction

  function automatic out_t o_done_only(input logic illegal);
    out_t o = '0;
    o.instr_done = 1'b1; o.illegal_op = illegal;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_env();
    for (int i = 0; i < 16; i++)  prog[i] = 16'h3000;
    for (int i = 0; i < 16; i++)  rf_init[i] = 8'h00;
    for (int i = 0; i < 256; i++) dmem_init[i] = 8'h00;
  endtask

  // Hold reset over two edges while reloading the environment, then release at a falling edge.
  task automatic start(input string tag);
    rst      = 1'b0;
    env_load = 1'b1;
    step(2);
    check({tag, "_rst_outputs"}, obs, o_idle());
    env_load = 1'b0;
    rst      = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    env_load = 1'b0;

    // Reset mid-ADD: run up to the ADD state, then pull reset.
    clear_env();
    prog[0] = 16'h3105; prog[1] = 16'h3203; prog[2] = 16'h2312;
    rf_init[3] = 8'hAA;
    start("t1");
    step(1); check("t1_first_fetch", obs, o_fetch(16'h0000));
    step(8); check("t1_add_state", obs, o_alu(4'h3, 4'h1, 4'h2, 2'b01));
    rst = 1'b0;
    #1 check("t1_outputs_in_reset", obs, o_idle());
    step(1); check("t1_outputs_held", obs, o_idle());
    check("t1_add_aborted", {56'h0, rf[3]}, 64'hAA);
    rst = 1'b1;
    check("t1_init_idle", obs, o_idle());
    step(1); check("t1_fetch_pc0", obs, o_fetch(16'h0000));

    // LDC, LDC, ADD with fresh register file.
    rf_init[3] = 8'h00;
    start("t2");
    step(1); check("t2_fetch0",  obs, o_fetch(16'h0000));
    step(1); check("t2_decode0", obs, o_idle());
    step(1); check("t2_ldc_r1",  obs, o_ldc(4'h1, 8'h05));
    step(1); check("t2_fetch1",  obs, o_fetch(16'h0001));
    step(2); check("t2_ldc_r2",  obs, o_ldc(4'h2, 8'h03));
    step(1); check("t2_fetch2",  obs, o_fetch(16'h0002));
    step(1); check("t2_decode2", obs, o_idle());
    step(1); check("t2_add",     obs, o_alu(4'h3, 4'h1, 4'h2, 2'b01));
    step(1); check("t2_fetch3",  obs, o_fetch(16'h0003));
    check("t2_r1", {56'h0, rf[1]}, 64'h05);
    check("t2_r2", {56'h0, rf[2]}, 64'h03);
    check("t2_r3", {56'h0, rf[3]}, 64'h08);

    // LOAD then STORE.
    clear_env();
    prog[0] = 16'h0409; prog[1] = 16'h1A20;
    dmem_init[9] = 8'h7E; rf_init[10] = 8'h33;
    start("t3");
    step(1); check("t3_fetch0", obs, o_fetch(16'h0000));
    step(2); check("t3_load",   obs, o_load(4'h4, 8'h09));
    step(1); check("t3_fetch1", obs, o_fetch(16'h0001));
    step(2); check("t3_store",  obs, o_store(4'hA, 8'h20));
    step(1); check("t3_fetch2", obs, o_fetch(16'h0002));
    check("t3_r4",      {56'h0, rf[4]},     64'h7E);
    check("t3_d20",     {56'h0, dmem[32]},  64'h33);

    // JMPZ at PC=4: taken with R1=0, then not taken with R1=1.
    clear_env();
    prog[0] = 16'h31FF; prog[1] = 16'h3901; prog[2] = 16'h3000;
    prog[3] = 16'h2119; prog[4] = 16'h51FE;
    start("t4");
    step(1);  check("t4_fetch0", obs, o_fetch(16'h0000));
    step(12); check("t4_fetch4", obs, o_fetch(16'h0004));
    check("t4_r1_zero", {56'h0, rf[1]}, 64'h00);
    step(2); check("t4_jmpz_taken", obs, o_jmpz(4'h1, 1'b0));
    step(1); check("t4_jmp",        obs, o_done_only(1'b0));
    step(1); check("t4_fetch2",     obs, o_fetch(16'h0002));
    step(6); check("t4_fetch4_again", obs, o_fetch(16'h0004));
    step(2); check("t4_jmpz_not_taken", obs, o_jmpz(4'h1, 1'b1));
    step(1); check("t4_fetch5",     obs, o_fetch(16'h0005));

    // JMPZ off=-1 at PC=0 wraps PC to 0xFFFF.
    clear_env();
    prog[0] = 16'h50FF;
    start("t5");
    step(1); check("t5_fetch0", obs, o_fetch(16'h0000));
    step(2); check("t5_jmpz",   obs, o_jmpz(4'h0, 1'b0));
    step(1); check("t5_jmp",    obs, o_done_only(1'b0));
    step(1); check("t5_fetch_wrap", obs, o_fetch(16'hFFFF));

    // Undefined opcode at PC=3.
    clear_env();
    prog[3] = 16'h7ABC;
    start("t6");
    step(10); check("t6_fetch3",  obs, o_fetch(16'h0003));
    step(1);  check("t6_illegal", obs, o_done_only(1'b1));
    step(1);  check("t6_fetch4",  obs, o_fetch(16'h0004));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
